// File: rtl/shadow_copy_sequencer.sv
// rtl/shadow_copy_sequencer.sv - copies a ROM image into shadow RAM word by word while holding the CPU in reset
// Optional read-back verify of every written word is compiled in with SHADOW_VERIFY_EN.
module shadow_copy_sequencer #(
    parameter logic [15:0] SRC_BASE = 16'h8000,
    parameter logic [15:0] DST_BASE = 16'h0000,
    parameter int unsigned WORDS    = 32768
) (
    input  logic        CopyClock,
    input  logic        Reset_n,
    input  logic        CopyStart,
    input  logic        Memory_Ack,
    input  logic [15:0] RdData,
    output logic [15:0] Addr,
    output logic [15:0] WrData,
    output logic        MemRd,
    output logic        MemWr,
    output logic        BusOwn,
    output logic        ResetReq,
    output logic        CopyDone,
    output logic        CopyError
);

    // 17-bit terminal index so WORDS=65536 still terminates.
    localparam logic [16:0] LAST_IDX = 17'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WRITE  = 3'd2,
        S_DONE   = 3'd3
`ifdef SHADOW_VERIFY_EN
        ,
        S_VERIFY = 3'd4,
        S_ERROR  = 3'd5
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] idx_q, idx_d;
    logic [15:0] wrdata_q, wrdata_d;
    logic        last_word;

    assign last_word = (idx_q == LAST_IDX);

    always_ff @(posedge CopyClock) begin
        if (!Reset_n) begin
            state_q  <= S_READ;
            idx_q    <= 17'd0;
            wrdata_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wrdata_q <= wrdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wrdata_d = wrdata_q;
        case (state_q)
            S_IDLE: begin
                if (CopyStart) begin
                    state_d = S_READ;
                    idx_d   = 17'd0;
                end
            end
            S_READ: begin
                if (Memory_Ack) begin
                    wrdata_d = RdData;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (Memory_Ack) begin
`ifdef SHADOW_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 17'd1;
                        state_d = S_READ;
                    end
`endif
                end
            end
`ifdef SHADOW_VERIFY_EN
            S_VERIFY: begin
                if (Memory_Ack) begin
                    if (RdData != wrdata_q) begin
                        state_d = S_ERROR;
                    end else if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 17'd1;
                        state_d = S_READ;
                    end
                end
            end
            S_ERROR: begin
                if (CopyStart) begin
                    state_d = S_IDLE;
                    idx_d   = 17'd0;
                end
            end
`endif
            S_DONE: begin
                if (CopyStart) begin
                    state_d = S_READ;
                    idx_d   = 17'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Only bus states own the bus; ResetReq drops solely in DONE.
    always_comb begin
        Addr      = 16'h0000;
        MemRd     = 1'b0;
        MemWr     = 1'b0;
        BusOwn    = 1'b0;
        ResetReq  = 1'b1;
        CopyDone  = 1'b0;
        CopyError = 1'b0;
        WrData    = wrdata_q;
        case (state_q)
            S_READ: begin
                Addr   = SRC_BASE + idx_q[15:0];
                MemRd  = 1'b1;
                BusOwn = 1'b1;
            end
            S_WRITE: begin
                Addr   = DST_BASE + idx_q[15:0];
                MemWr  = 1'b1;
                BusOwn = 1'b1;
            end
`ifdef SHADOW_VERIFY_EN
            S_VERIFY: begin
                Addr   = DST_BASE + idx_q[15:0];
                MemRd  = 1'b1;
                BusOwn = 1'b1;
            end
            S_ERROR: begin
                CopyError = 1'b1;
            end
`endif
            S_DONE: begin
                ResetReq = 1'b0;
                CopyDone = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shadow_copy_sequencer.sv
// tb/tb_shadow_copy_sequencer.sv - scoreboard bench for shadow_copy_sequencer
module tb_shadow_copy_sequencer;

`ifdef SHADOW_VERIFY_EN
    localparam int CPW = 3;
`else
    localparam int CPW = 2;
`endif
    localparam int EXP_CYC = 4 * CPW;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        a_rstn = 1'b0, a_start = 1'b0, a_ack;
    logic        b_rstn = 1'b0, b_start = 1'b0, b_ack;
    logic [15:0] a_addr, a_wd, b_addr, b_wd, rd_data;
    logic        a_rd, a_wr, a_bus, a_rr, a_done, a_err;
    logic        b_rd, b_wr, b_bus, b_rr, b_done, b_err;

    logic [15:0] mem [0:65535];
    logic [15:0] mdl [0:65535];
    acc_t        exp_q[$];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        corrupt = 1'b0;
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = 16'h0, poke_data = 16'h0;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    logic [15:0] s_addr, s_wd;
    logic        s_rd, s_wr, s_bus, s_done, s_rstn, s_ack_raw;

    assign s_addr    = sel ? b_addr : a_addr;
    assign s_wd      = sel ? b_wd   : a_wd;
    assign s_rd      = sel ? b_rd   : a_rd;
    assign s_wr      = sel ? b_wr   : a_wr;
    assign s_bus     = sel ? b_bus  : a_bus;
    assign s_done    = sel ? b_done : a_done;
    assign s_rstn    = sel ? b_rstn : a_rstn;
    assign s_ack_raw = (s_rd || s_wr) && (wait_cnt == ack_delay);
    assign a_ack     = !sel && s_ack_raw;
    assign b_ack     = sel && s_ack_raw;

    always_comb begin
        rd_data = mem[s_addr];
        if (corrupt && s_addr == 16'h0001) rd_data = mem[s_addr] ^ 16'h00FF;
    end

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (s_wr && s_ack_raw) mem[s_addr] <= s_wd;
        if (!(s_rd || s_wr) || s_ack_raw) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    shadow_copy_sequencer #(.SRC_BASE(16'h8000), .DST_BASE(16'h0000), .WORDS(4)) dut_a (
        .CopyClock(clk), .Reset_n(a_rstn), .CopyStart(a_start), .Memory_Ack(a_ack),
        .RdData(rd_data), .Addr(a_addr), .WrData(a_wd), .MemRd(a_rd), .MemWr(a_wr),
        .BusOwn(a_bus), .ResetReq(a_rr), .CopyDone(a_done), .CopyError(a_err)
    );

    shadow_copy_sequencer #(.SRC_BASE(16'hFFFE), .DST_BASE(16'h0000), .WORDS(4)) dut_b (
        .CopyClock(clk), .Reset_n(b_rstn), .CopyStart(b_start), .Memory_Ack(b_ack),
        .RdData(rd_data), .Addr(b_addr), .WrData(b_wd), .MemRd(b_rd), .MemWr(b_wr),
        .BusOwn(b_bus), .ResetReq(b_rr), .CopyDone(b_done), .CopyError(b_err)
    );

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Expected bus accesses of a copy, played against a private copy of memory.
    task automatic push_copy(input logic [15:0] src, input logic [15:0] dst, input int words, input int stop_idx);
        logic [15:0] ra, wa, d;
        mdl = mem;
        for (int i = 0; i < words; i++) begin
            ra = src + 16'(i);
            wa = dst + 16'(i);
            d  = mdl[ra];
            exp_q.push_back({1'b0, ra, d});
            exp_q.push_back({1'b1, wa, d});
            mdl[wa] = d;
`ifdef SHADOW_VERIFY_EN
            exp_q.push_back({1'b0, wa, d});
`endif
            if (i == stop_idx) break;
        end
    endtask

    task automatic pulse_start();
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1 cycles++;
        end while (!s_done && cycles < budget);
        checks++;
        if (!s_done) begin
            failures++;
            $display("FAIL done_timeout got CopyDone=%0b after %0d cycles, required 1", s_done, cycles);
        end
    endtask

    task automatic monitor_loop();
        acc_t        e;
        logic        prev_pending = 1'b0;
        logic [15:0] prev_addr = 16'h0, prev_wd = 16'h0;
        logic        prev_rd = 1'b0, prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (!s_rstn || !mon_en) begin
                prev_pending = 1'b0;
                continue;
            end
            if (prev_pending) begin
                checks++;
                if (s_addr !== prev_addr || s_wd !== prev_wd || s_rd !== prev_rd || s_wr !== prev_wr) begin
                    failures++;
                    $display("FAIL hold_stable got addr=%h wd=%h rd=%0b wr=%0b, required addr=%h wd=%h rd=%0b wr=%0b",
                             s_addr, s_wd, s_rd, s_wr, prev_addr, prev_wd, prev_rd, prev_wr);
                end
            end
            if (s_bus && (s_rd || s_wr) && s_ack_raw) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_extra got wr=%0b addr=%h, required no access", s_wr, s_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (s_wr !== e.wr || s_addr !== e.addr || (e.wr && s_wd !== e.data)) begin
                        failures++;
                        $display("FAIL scoreboard got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                                 s_wr, s_addr, s_wd, e.wr, e.addr, e.data);
                    end
                end
            end
            prev_pending = (s_rd || s_wr) && !s_ack_raw;
            prev_addr    = s_addr;
            prev_wd      = s_wd;
            prev_rd      = s_rd;
            prev_wr      = s_wr;
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending got %0d outstanding accesses, required 0", name, exp_q.size());
        end
    endtask

    task automatic check_ram(input string name, input logic [63:0] want);
        logic [63:0] got;
        got = {mem[16'h0000], mem[16'h0001], mem[16'h0002], mem[16'h0003]};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s_ram got %h, required %h", name, got, want);
        end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 4; i++) poke(16'(i), 16'h0000);
    endtask

    task automatic test_reset();
        poke(16'h8000, 16'h00A1);
        poke(16'h8001, 16'h00B2);
        poke(16'h8002, 16'h00C3);
        poke(16'h8003, 16'h00D4);
        poke(16'hFFFE, 16'h5E5E);
        poke(16'hFFFF, 16'h7F7F);
        clear_ram();
        checks++;
        if (a_addr !== 16'h8000 || a_wd !== 16'h0000) begin
            failures++;
            $display("FAIL reset_bus got addr=%h wd=%h, required addr=8000 wd=0000", a_addr, a_wd);
        end
        checks++;
        if ({a_rd, a_wr, a_bus, a_rr, a_done, a_err} !== 6'b101100) begin
            failures++;
            $display("FAIL reset_flags got rd,wr,bus,rr,done,err=%b, required 101100",
                     {a_rd, a_wr, a_bus, a_rr, a_done, a_err});
        end
    endtask

    task automatic test_basic_copy();
        push_copy(16'h8000, 16'h0000, 4, -1);
        mon_en = 1'b1;
        a_rstn = 1'b1;
        for (int n = 1; n <= EXP_CYC; n++) begin
            @(posedge clk);
            #1;
            if (n == EXP_CYC - 1) begin
                checks++;
                if (a_done !== 1'b0 || a_rr !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_early got done=%0b rr=%0b at cycle %0d, required done=0 rr=1", a_done, a_rr, n);
                end
            end
        end
        checks++;
        if (a_done !== 1'b1 || a_rr !== 1'b0 || a_bus !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_edge got done=%0b rr=%0b bus=%0b, required done=1 rr=0 bus=0", a_done, a_rr, a_bus);
        end
        check_queue_empty("basic");
        check_ram("basic", 64'h00A1_00B2_00C3_00D4);
    endtask

    task automatic test_ack_delay();
        int cyc;
        clear_ram();
        ack_delay = 3;
        push_copy(16'h8000, 16'h0000, 4, -1);
        pulse_start();
        wait_done(400, cyc);
        check_queue_empty("delay");
        check_ram("delay", 64'h00A1_00B2_00C3_00D4);
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_copy();
        int cyc;
        int guard;
        clear_ram();
        push_copy(16'h8000, 16'h0000, 4, -1);
        pulse_start();
        guard = 0;
        while (!(a_rd && a_addr == 16'h8002) && guard < 50) begin
            @(posedge clk);
            #1 guard++;
        end
        checks++;
        if (!(a_rd && a_addr == 16'h8002)) begin
            failures++;
            $display("FAIL midreset_reach got addr=%h rd=%0b, required addr=8002 rd=1", a_addr, a_rd);
        end
        a_rstn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (a_addr !== 16'h8000 || a_done !== 1'b0 || a_rr !== 1'b1) begin
            failures++;
            $display("FAIL midreset_restart got addr=%h done=%0b rr=%0b, required addr=8000 done=0 rr=1", a_addr, a_done, a_rr);
        end
        exp_q.delete();
        push_copy(16'h8000, 16'h0000, 4, -1);
        a_rstn = 1'b1;
        wait_done(100, cyc);
        checks++;
        if (cyc != EXP_CYC) begin
            failures++;
            $display("FAIL midreset_cycles got %0d, required %0d", cyc, EXP_CYC);
        end
        check_queue_empty("midreset");
        check_ram("midreset", 64'h00A1_00B2_00C3_00D4);
    endtask

    task automatic test_start_handling();
        int cyc;
        clear_ram();
        push_copy(16'h8000, 16'h0000, 4, -1);
        pulse_start();
        checks++;
        if (a_rr !== 1'b1 || a_done !== 1'b0 || a_bus !== 1'b1) begin
            failures++;
            $display("FAIL restart_from_done got rr=%0b done=%0b bus=%0b, required rr=1 done=0 bus=1", a_rr, a_done, a_bus);
        end
        repeat (3) @(posedge clk);
        #1 pulse_start();
        wait_done(100, cyc);
        checks++;
        if (cyc != EXP_CYC - 4) begin
            failures++;
            $display("FAIL midstart_cycles got %0d, required %0d", cyc, EXP_CYC - 4);
        end
        check_queue_empty("midstart");
        check_ram("midstart", 64'h00A1_00B2_00C3_00D4);
    endtask

`ifdef SHADOW_VERIFY_EN
    task automatic test_verify_error();
        int cyc;
        int guard;
        clear_ram();
        corrupt = 1'b1;
        push_copy(16'h8000, 16'h0000, 4, 1);
        pulse_start();
        guard = 0;
        while (!a_err && guard < 100) begin
            @(posedge clk);
            #1 guard++;
        end
        checks++;
        if (a_err !== 1'b1 || a_rr !== 1'b1 || a_bus !== 1'b0 || a_done !== 1'b0) begin
            failures++;
            $display("FAIL verify_error got err=%0b rr=%0b bus=%0b done=%0b, required err=1 rr=1 bus=0 done=0",
                     a_err, a_rr, a_bus, a_done);
        end
        check_queue_empty("verify_err");
        corrupt = 1'b0;
        pulse_start();
        checks++;
        if (a_err !== 1'b0 || a_rr !== 1'b1 || a_bus !== 1'b0) begin
            failures++;
            $display("FAIL verify_idle got err=%0b rr=%0b bus=%0b, required err=0 rr=1 bus=0", a_err, a_rr, a_bus);
        end
        push_copy(16'h8000, 16'h0000, 4, -1);
        pulse_start();
        wait_done(100, cyc);
        checks++;
        if (a_err !== 1'b0) begin
            failures++;
            $display("FAIL verify_rerun_err got err=%0b, required 0", a_err);
        end
        check_queue_empty("verify_rerun");
        check_ram("verify_rerun", 64'h00A1_00B2_00C3_00D4);
    endtask
`endif

    task automatic test_wrap();
        int cyc;
        sel = 1'b1;
        push_copy(16'hFFFE, 16'h0000, 4, -1);
        b_rstn = 1'b1;
        wait_done(100, cyc);
        checks++;
        if (cyc != EXP_CYC || b_err !== 1'b0) begin
            failures++;
            $display("FAIL wrap_done got cycles=%0d err=%0b, required cycles=%0d err=0", cyc, b_err, EXP_CYC);
        end
        check_queue_empty("wrap");
        check_ram("wrap", 64'h5E5E_7F7F_5E5E_7F7F);
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        @(posedge clk);
        #1;
        test_reset();
        test_basic_copy();
        test_ack_delay();
        test_reset_mid_copy();
        test_start_handling();
`ifdef SHADOW_VERIFY_EN
        test_verify_error();
`endif
        test_wrap();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
